// File: rtl/vga_pkg.sv
// Shared constants for the tile scanout path: display mode timings, pipeline latency,
// RGB444 colour type and the default palette.
package vga_pkg;

   typedef logic [11:0] rgb_t;

   typedef struct packed {
      int h_res;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_res;
      int v_fp;
      int v_sync;
      int v_bp;
   } vga_mode_t;

   localparam vga_mode_t MODE_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam vga_mode_t MODE_720X400 = '{720, 18, 108, 54, 400, 12, 2, 35};
   localparam vga_mode_t MODE_720X480 = '{720, 16, 62, 60, 480, 9, 6, 30};

   // Counter value to pixel-out latency; every sync/enable path is delayed to match.
   localparam int LAT   = 4;
   localparam int CNT_W = 12;

   localparam rgb_t PAL0_DEF = 12'h000;
   localparam rgb_t PAL1_DEF = 12'h0F0;
   localparam rgb_t PAL2_DEF = 12'hF80;
   localparam rgb_t PAL3_DEF = 12'hFFF;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with undelayed sync, active and frame-start flags.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_RES  = MODE_640X480.h_res,
   parameter int H_FP   = MODE_640X480.h_fp,
   parameter int H_SYNC = MODE_640X480.h_sync,
   parameter int H_BP   = MODE_640X480.h_bp,
   parameter int H_NEG  = 1,
   parameter int V_RES  = MODE_640X480.v_res,
   parameter int V_FP   = MODE_640X480.v_fp,
   parameter int V_SYNC = MODE_640X480.v_sync,
   parameter int V_BP   = MODE_640X480.v_bp,
   parameter int V_NEG  = 1
)(
   input  logic             clock,
   input  logic             reset_n,
   output logic [CNT_W-1:0] o_h,
   output logic [CNT_W-1:0] o_v,
   output logic             o_hs,
   output logic             o_vs,
   output logic             o_de,
   output logic             o_fs
);
   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] r_h, r_v;
   logic             w_h_wrap, w_v_wrap;

   assign w_h_wrap = (r_h == CNT_W'(H_TOTAL - 1));
   assign w_v_wrap = (r_v == CNT_W'(V_TOTAL - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_h <= '0;
         r_v <= '0;
      end else begin
         r_h <= w_h_wrap ? '0 : r_h + 1'b1;
         if (w_h_wrap)
            r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end
   end

   assign o_h  = r_h;
   assign o_v  = r_v;
   // XOR with the polarity flag turns "in sync window" into the pin level.
   assign o_hs = ((r_h >= CNT_W'(H_RES + H_FP)) && (r_h < CNT_W'(H_RES + H_FP + H_SYNC))) ^ (H_NEG != 0);
   assign o_vs = ((r_v >= CNT_W'(V_RES + V_FP)) && (r_v < CNT_W'(V_RES + V_FP + V_SYNC))) ^ (V_NEG != 0);
   assign o_de = (r_h < CNT_W'(H_RES)) && (r_v < CNT_W'(V_RES));
   assign o_fs = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_tile_scanout.sv
// Tile-map video scanout: map/tile BRAM fetch pipeline, palette lookup and sync alignment.
// Optional scrolling is enabled by defining VGA_SCROLL_EN.
module vga_tile_scanout
   import vga_pkg::*;
#(
   parameter int   H_RES         = MODE_640X480.h_res,
   parameter int   H_FP          = MODE_640X480.h_fp,
   parameter int   H_SYNC        = MODE_640X480.h_sync,
   parameter int   H_BP          = MODE_640X480.h_bp,
   parameter int   H_NEG         = 1,
   parameter int   V_RES         = MODE_640X480.v_res,
   parameter int   V_FP          = MODE_640X480.v_fp,
   parameter int   V_SYNC        = MODE_640X480.v_sync,
   parameter int   V_BP          = MODE_640X480.v_bp,
   parameter int   V_NEG         = 1,
   parameter int   SCALE_LOG2    = 1,
   parameter int   MAP_COLS_LOG2 = 5,
   parameter int   MAP_AW        = 9,
   parameter rgb_t PAL0          = PAL0_DEF,
   parameter rgb_t PAL1          = PAL1_DEF,
   parameter rgb_t PAL2          = PAL2_DEF,
   parameter rgb_t PAL3          = PAL3_DEF
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        MD,
   input  logic [15:0]       TD,
   input  logic [9:0]        scroll_x,
   input  logic [9:0]        scroll_y,
   output logic [MAP_AW-1:0] MA,
   output logic [10:0]       TA,
   output logic [3:0]        R,
   output logic [3:0]        G,
   output logic [3:0]        B,
   output logic              hs,
   output logic              vs,
   output logic              de,
   output logic              frame_start
);
   localparam logic [16:0] COL_MASK = 17'((1 << MAP_COLS_LOG2) - 1);

   logic [CNT_W-1:0] w_h, w_v;
   logic             w_hs, w_vs, w_de, w_fs;

   vga_timing #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_NEG(H_NEG),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_NEG(V_NEG)
   ) u_timing (
      .clock(clock), .reset_n(reset_n),
      .o_h(w_h), .o_v(w_v), .o_hs(w_hs), .o_vs(w_vs), .o_de(w_de), .o_fs(w_fs)
   );

   logic [9:0] w_sx, w_sy, w_px, w_py;

`ifdef VGA_SCROLL_EN
   logic [9:0] r_sx, r_sy;

   // Latched once per frame at the top of vblank so a frame never shows two offsets.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sx <= '0;
         r_sy <= '0;
      end else if ((w_h == '0) && (w_v == CNT_W'(V_RES))) begin
         r_sx <= scroll_x;
         r_sy <= scroll_y;
      end
   end

   assign w_sx = r_sx;
   assign w_sy = r_sy;
`else
   logic w_unused_scroll;
   assign w_unused_scroll = ^{scroll_x, scroll_y};
   assign w_sx = '0;
   assign w_sy = '0;
`endif

   assign w_px = 10'(w_h >> SCALE_LOG2) + w_sx;
   assign w_py = 10'(w_v >> SCALE_LOG2) + w_sy;

   logic [MAP_AW-1:0] r_ma;
   logic [2:0]        r_px1, r_px2, r_px3, r_py1, r_py2;
   rgb_t              r_rgb, w_pal;
   logic [1:0]        w_pix;
   logic [LAT:1]      r_vld_pipe, r_hs_pipe, r_vs_pipe, r_fs_pipe;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ma       <= '0;
         r_px1      <= '0;
         r_px2      <= '0;
         r_px3      <= '0;
         r_py1      <= '0;
         r_py2      <= '0;
         r_rgb      <= '0;
         r_vld_pipe <= '0;
         r_fs_pipe  <= '0;
         r_hs_pipe  <= {LAT{(H_NEG != 0)}};
         r_vs_pipe  <= {LAT{(V_NEG != 0)}};
      end else begin
         // Map row from py, column wraps at the map width, whole address wraps at MAP_AW.
         r_ma       <= MAP_AW'((17'(w_py[9:3]) << MAP_COLS_LOG2) | (17'(w_px[9:3]) & COL_MASK));
         r_px1      <= w_px[2:0];
         r_px2      <= r_px1;
         r_px3      <= r_px2;
         r_py1      <= w_py[2:0];
         r_py2      <= r_py1;
         r_rgb      <= r_vld_pipe[LAT-1] ? w_pal : '0;
         r_vld_pipe <= {r_vld_pipe[LAT-1:1], w_de};
         r_fs_pipe  <= {r_fs_pipe[LAT-1:1], w_fs};
         r_hs_pipe  <= {r_hs_pipe[LAT-1:1], w_hs};
         r_vs_pipe  <= {r_vs_pipe[LAT-1:1], w_vs};
      end
   end

   // Pixel 0 sits in TD[15:14]: shift right by 2*(7-px).
   assign w_pix = 2'(TD >> {~r_px3, 1'b0});

   always_comb begin
      w_pal = PAL0;
      case (w_pix)
         2'd0: w_pal = PAL0;
         2'd1: w_pal = PAL1;
         2'd2: w_pal = PAL2;
         2'd3: w_pal = PAL3;
         default: w_pal = PAL0;
      endcase
   end

   assign MA          = r_ma;
   assign TA          = reset_n ? {MD, r_py2} : '0;
   assign {R, G, B}   = r_rgb;
   assign hs          = r_hs_pipe[LAT];
   assign vs          = r_vs_pipe[LAT];
   assign de          = r_vld_pipe[LAT];
   assign frame_start = r_fs_pipe[LAT];

endmodule

// File: doc/vga_tile_scanout.md
Name: vga_tile_scanout

Overview:
Parametrised successor to the fixed 640x480 tile front-panel video path. It generates VGA timing from module parameters instead of hard-coded resolution macros, and fetches map and tile BRAM data through a fixed-latency pipeline. It outputs palette-mapped 12-bit RGB with sync and data-enable aligned to the pixels. It sits in the clk_vga domain between map_bram/tile_bram and the VGA pins. Adds pixel scaling, a configurable map width and a frame-start strobe.

Parameters:
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
H_NEG, 1, 1 = hsync active-low
V_RES, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
V_NEG, 1, 1 = vsync active-low
SCALE_LOG2, 1, each map pixel is 2^SCALE_LOG2 screen pixels in both axes (0..2)
MAP_COLS_LOG2, 5, map width in tiles, power of two
MAP_AW, 9, map address width
PAL0..PAL3, 12'h000/12'h0F0/12'hF80/12'hFFF, RGB444 palette entries

Ports:
clock  in  1  pixel clock (clk_vga)
reset_n  in  1  asynchronous active-low reset
MD  in  8  map data (tile index), valid 1 cycle after MA
TD  in  16  tile row data, 8 pixels x 2 bpp, pixel 0 in [15:14], valid 1 cycle after TA
scroll_x  in  10  horizontal scroll in map pixels (used only with VGA_SCROLL_EN)
scroll_y  in  10  vertical scroll in map pixels (used only with VGA_SCROLL_EN)
MA  out  MAP_AW  map BRAM address
TA  out  11  tile BRAM address {tile_index, row[2:0]}
R, G, B  out  4 each  colour
hs, vs  out  1 each  sync, polarity per H_NEG/V_NEG
de  out  1  data enable
frame_start  out  1  one-cycle pulse at first active pixel of each frame, aligned with de

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: h/v counters 0; hs = H_NEG, vs = V_NEG (inactive levels); de 0; R/G/B 0; MA 0; TA 0; frame_start 0; all pipeline valid bits 0.
- Counters: h runs 0..H_TOTAL-1, where H_TOTAL = H_RES+H_FP+H_SYNC+H_BP. v increments when h wraps and runs 0..V_TOTAL-1. Active region: h<H_RES and v<V_RES.
- Sync timing: sync is asserted for h in [H_RES+H_FP, H_RES+H_FP+H_SYNC); the same rule applies to v.
- Coordinates: px = (h >> SCALE_LOG2) + sx and py = (v >> SCALE_LOG2) + sy. sx/sy = scroll values (0 without the macro). Width 10 bits, wrapping mod 1024.
- Pipeline, counter value at cycle k:
  - k+1: MA registered = {py[.. :3], px[MAP_COLS_LOG2+2:3]}, truncated to MAP_AW; px[2:0] and py[2:0] delayed alongside.
  - k+2: MD valid; TA = {MD, py_d[2:0]} driven combinationally.
  - k+3: TD valid.
  - k+4: R/G/B registered from palette[TD[15-2*px_d[2:0] -: 2]].
- Latency: LAT = 4. hs, vs, de and frame_start pass through a matching 4-stage delay, so pixel (0,0) colour and de=1 appear together.
- Blanking: R/G/B = 0 whenever delayed de = 0.
- Map wrap: map column wraps mod 2^MAP_COLS_LOG2 and the map address wraps mod 2^MAP_AW. No out-of-range detection.
- frame_start: high exactly one cycle, when the delayed (h,v) = (0,0).
- Reset mid-frame: restarts from (0,0). Pipeline contents are discarded, and de stays 0 for the first LAT cycles after release.
- Scroll sampling (with macro): scroll_x/scroll_y are captured only at h=0, v=V_RES, so no mid-frame tearing.

Optional Feature:
VGA_SCROLL_EN
- Defined: scroll_x/scroll_y are registered at the start of vblank and added to the coordinates as above.
- Undefined: the scroll ports are present but ignored; sx = sy = 0 and no scroll registers are synthesised.

Decomposition:
- Shared package vga_pkg: timing-parameter defaults for the 640x480, 720x400 and 720x480 modes; the LAT constant; the RGB444 colour typedef; the default palette constants.
- One sub-module, vga_timing: counters, sync/de/active generation and frame_start.
- vga_tile_scanout keeps the fetch pipeline, palette lookup and delay alignment.

Test Plan:
- Reset, then free-run with defaults. Required: hs period 800 clocks, low for 96 clocks beginning 656 clocks after line start; vs period 525 lines, low for 2 lines; de high 640x480 per frame.
- BRAM models with MD=0x03 and TD=16'h1B1B. Required: first active pixels give RGB = PAL0, PAL1, PAL2, PAL3 repeating; each pixel held 2 clocks at SCALE_LOG2=1; first colour coincident with first de=1.
- Address check. Required: MA at h=32, v=0 is 2 (SCALE 1); at v=16, h=0, MA is 32; TA equals {MD, 3'd1} at v=2.
- Pulse and latency check. Required: frame_start exactly one pulse per frame, coincident with first de; latency from counter (0,0) to RGB is 4 clocks.
- Assert reset_n low at h=300, v=200, release 3 cycles later. Required: outputs take reset values immediately; de returns only at the next (0,0)+LAT.
- With VGA_SCROLL_EN, scroll_x=8 changed mid-frame. Required: no effect until the next frame; then MA offset +1.
